av_ram_arbiter: RTL
===================

Name: av_ram_arbiter

Overview:
- Two-port Avalon-MM arbiter that shares one simple dual-port, byte-enabled, 32-bit synchronous RAM (1-cycle registered read) between two masters, e.g. instruction fetch (port 0) and data (port 1).
- Grants at most one access per cycle and drives the RAM's we/din/waddr/raddr.
- Returns read data with readdatavalid, one cycle after the grant.
- Sits between the masters' interconnect and the RAM instance.

Parameters:
depth, 256, RAM depth in 32-bit words; address width AW = $clog2(depth)
fixed_prio, 0, 0 = round-robin between ports; 1 = port 0 always wins

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  asynchronous, active-high reset
p0_address  in  AW  port 0 word address
p0_read  in  1  port 0 read request
p0_write  in  1  port 0 write request
p0_writedata  in  32  port 0 write data
p0_byteenable  in  4  port 0 byte enables
p0_waitrequest  out  1  port 0 stall (combinational)
p0_readdata  out  32  port 0 read data
p0_readdatavalid  out  1  port 0 read data valid
p1_*  same set as p0_*, for port 1
ram_we  out  4  RAM byte write enables
ram_din  out  32  RAM write data
ram_waddr  out  AW  RAM write address
ram_raddr  out  AW  RAM read address
ram_dout  in  32  RAM registered read data

Behaviour:
- Request: reqN = pN_read | pN_write.
- Grant (combinational): one port per cycle.
  - If only one port requests, it wins.
  - If both request and fixed_prio=1, port 0 wins.
  - If both request and fixed_prio=0, the port named by the registered priority pointer `last` wins. `last` holds the loser of the most recent contested cycle.
  - `last` updates only on contested cycles. Reset value: port 0 has priority.
- pN_waitrequest = rst | (reqN & ~grantN).
  - An ungranted master holds its request stable, per Avalon rules.
  - With no request, waitrequest is 0.
- RAM drive (combinational, from the granted port):
  - ram_waddr = ram_raddr = granted address.
  - ram_din = granted writedata.
  - ram_we = byteenable when the granted access is a write, else 4'b0000.
  - ram_we = 0 while rst is high or with no grant.
  - When nothing is granted, address and data are don't-care but must not be X: drive port 0 values.
- Read pipeline:
  - Registers rd_pend (1 bit) and rd_port (1 bit) capture a granted read.
  - One cycle later, pX_readdatavalid = rd_pend & (rd_port==X).
  - pX_readdata = ram_dout in that cycle.
  - Back-to-back reads from either or both ports sustain one read per cycle, returned in grant order.
  - Read latency is exactly 1 cycle after the grant edge.
- Read and write asserted together on one port is illegal.
  - Write takes precedence.
  - No readdatavalid is produced for that access.
- Ordering: a write granted in cycle N followed by a read of the same address granted in cycle N+1 returns the new data. The RAM is updated at the edge ending cycle N.
- byteenable = 0 on a write: granted and completed, no RAM bytes change.
- Reset, asynchronous:
  - rd_pend=0, rd_port=0, `last` → port 0 priority.
  - All readdatavalid=0, all waitrequest=1, ram_we=0.
  - readdata follows ram_dout and is don't-care while valid=0.
  - A read granted in the cycle reset asserts is dropped: no valid ever appears.
- No storage of write data or addresses: the block is a single-cycle-decision arbiter plus a 1-deep read return tag.

Test Plan:
1. Reset: assert rst mid-read burst → readdatavalid 0 on both ports, waitrequest 1 on both, ram_we 0; after release with no requests, waitrequest 0.
2. Single port: p1 writes 0xDEADBEEF at addr 5 with be=4'b1111, then reads addr 5 on the next cycle → p1_readdatavalid high exactly one cycle after the read grant, p1_readdata=0xDEADBEEF, p0 sees no valid.
3. Byte enables: write 0x11223344 with be=4'b0101 over 0xFFFFFFFF at addr 2, then read → 0xFF22FF44.
4. Contention, fixed_prio=0: both ports read continuously for 6 cycles → grants alternate 0,1,0,1,0,1; each port gets 3 readdatavalid pulses with correct data, in order; waitrequest high on the losing port each cycle.
5. Contention, fixed_prio=1: both request for 4 cycles → port 0 granted every cycle, p1_waitrequest held 1; p1 is granted on the first cycle p0 drops its request.
6. Illegal read+write on p0 with write 0xA5A5A5A5 at addr 7 → RAM written, no p0_readdatavalid; a subsequent read of addr 7 returns 0xA5A5A5A5.

Source files
------------

// File: rtl/av_ram_arbiter.sv
// av_ram_arbiter: two-port Avalon-MM arbiter in front of one simple dual-port,
// byte-enabled, 32-bit RAM with a 1-cycle registered read. Grant and RAM drive
// are combinational. A 1-deep tag routes each read return to the port that
// issued the read.
module av_ram_arbiter #(
   parameter int unsigned depth      = 256,
   parameter bit          fixed_prio = 1'b0,
   localparam int unsigned AW        = (depth > 1) ? $clog2(depth) : 1
) (
   input  logic          clk,
   input  logic          rst,

   input  logic [AW-1:0] p0_address,
   input  logic          p0_read,
   input  logic          p0_write,
   input  logic [31:0]   p0_writedata,
   input  logic [3:0]    p0_byteenable,
   output logic          p0_waitrequest,
   output logic [31:0]   p0_readdata,
   output logic          p0_readdatavalid,

   input  logic [AW-1:0] p1_address,
   input  logic          p1_read,
   input  logic          p1_write,
   input  logic [31:0]   p1_writedata,
   input  logic [3:0]    p1_byteenable,
   output logic          p1_waitrequest,
   output logic [31:0]   p1_readdata,
   output logic          p1_readdatavalid,

   output logic [3:0]    ram_we,
   output logic [31:0]   ram_din,
   output logic [AW-1:0] ram_waddr,
   output logic [AW-1:0] ram_raddr,
   input  logic [31:0]   ram_dout
);

   // Priority pointer: names the port that wins the next contested cycle.
   typedef enum logic {
      PRIO_P0 = 1'b0,
      PRIO_P1 = 1'b1
   } prio_t;

   prio_t         r_last;
   prio_t         w_last_nxt;
   logic          r_rd_pend;
   logic          w_rd_pend_nxt;
   logic          r_rd_port;
   logic          w_rd_port_nxt;

   logic          w_req0;
   logic          w_req1;
   logic          w_contest;
   logic          w_gnt0;
   logic          w_gnt1;
   logic          w_gnt_wr;
   logic          w_gnt_rd;

   assign w_req0    = p0_read | p0_write;
   assign w_req1    = p1_read | p1_write;
   assign w_contest = w_req0 & w_req1;

   // Grant decision: lone requester wins; contested cycles use fixed or rotating priority.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (!rst) begin
         if (w_contest) begin
            if (fixed_prio || (r_last == PRIO_P0)) begin
               w_gnt0 = 1'b1;
            end else begin
               w_gnt1 = 1'b1;
            end
         end else if (w_req0) begin
            w_gnt0 = 1'b1;
         end else if (w_req1) begin
            w_gnt1 = 1'b1;
         end
      end
   end

   // Stall any requester that was not granted; everyone stalls during reset.
   assign p0_waitrequest = rst | (w_req0 & ~w_gnt0);
   assign p1_waitrequest = rst | (w_req1 & ~w_gnt1);

   // RAM drive from the granted port; port 0 values when idle keep the bus X-free.
   always_comb begin
      ram_waddr = p0_address;
      ram_din   = p0_writedata;
      ram_we    = 4'b0000;
      w_gnt_wr  = 1'b0;
      w_gnt_rd  = 1'b0;
      if (w_gnt1) begin
         ram_waddr = p1_address;
         ram_din   = p1_writedata;
         w_gnt_wr  = p1_write;
         w_gnt_rd  = p1_read & ~p1_write;
         if (p1_write) begin
            ram_we = p1_byteenable;
         end
      end else if (w_gnt0) begin
         w_gnt_wr  = p0_write;
         w_gnt_rd  = p0_read & ~p0_write;
         if (p0_write) begin
            ram_we = p0_byteenable;
         end
      end
   end

   assign ram_raddr = ram_waddr;

   // Next state: read tag follows the grant; pointer moves to the loser on contested cycles.
   always_comb begin
      w_last_nxt    = r_last;
      w_rd_pend_nxt = w_gnt_rd;
      w_rd_port_nxt = w_gnt1;
      if (w_contest && (w_gnt0 || w_gnt1)) begin
         w_last_nxt = w_gnt0 ? PRIO_P1 : PRIO_P0;
      end
   end

   // State registers; async reset drops any read in flight and favours port 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last    <= PRIO_P0;
         r_rd_pend <= 1'b0;
         r_rd_port <= 1'b0;
      end else begin
         r_last    <= w_last_nxt;
         r_rd_pend <= w_rd_pend_nxt;
         r_rd_port <= w_rd_port_nxt;
      end
   end

   // Read return: RAM output goes to both ports, valid only to the tagged one.
   assign p0_readdata      = ram_dout;
   assign p1_readdata      = ram_dout;
   assign p0_readdatavalid = r_rd_pend & ~r_rd_port;
   assign p1_readdatavalid = r_rd_pend &  r_rd_port;

   // The write flag is folded into ram_we; kept as a named net for readability.
   logic w_unused;
   assign w_unused = w_gnt_wr;

endmodule
